// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: tags, ALU control, and reservation-station bundles.
// Reservation-station types (rs_src_s, rs_disp_s, rs_entry_s) live here for reuse by other stations.
// src_snoop captures a CDB broadcast into a waiting operand.
package riscv_pkg;

    localparam int TAG_WIDTH = 6;
    localparam int XLEN      = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    // Bundle presented to a functional unit
    typedef struct packed {
        logic                 valid;
        alu_ctrl_e            alu_ctrl;
        logic [XLEN-1:0]      operand_a;
        logic [XLEN-1:0]      operand_b;
        logic [TAG_WIDTH-1:0] dest_tag;
    } rs_fu_s;

    // One source operand: either ready with data, or waiting on a producer tag
    typedef struct packed {
        logic                 rdy;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } rs_src_s;

    typedef struct packed {
        alu_ctrl_e            alu_ctrl;
        logic [TAG_WIDTH-1:0] dest_tag;
        rs_src_s              src_a;
        rs_src_s              src_b;
    } rs_disp_s;

    typedef struct packed {
        logic                 valid;
        alu_ctrl_e            alu_ctrl;
        logic [TAG_WIDTH-1:0] dest_tag;
        rs_src_s              src_a;
        rs_src_s              src_b;
    } rs_entry_s;

    // A waiting operand whose tag matches a valid broadcast becomes ready with the broadcast data
    function automatic rs_src_s src_snoop(input rs_src_s s, input logic cdb_valid,
                                          input logic [TAG_WIDTH-1:0] cdb_tag,
                                          input logic [XLEN-1:0] cdb_data);
        rs_src_s r;
        r = s;
        if (!s.rdy && cdb_valid && (s.tag == cdb_tag)) begin
            r.rdy  = 1'b1;
            r.data = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsb_pick.sv
// Lowest-set-bit picker: one-hot of the lowest requesting bit plus an any-set flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to do with the pick.
module lsb_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             found_o
);

    // Two's-complement trick isolates the lowest set bit
    assign onehot_o = req_i & (~req_i + WIDTH'(1));
    assign found_o  = |req_i;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDB, issues lowest ready entry.
// Latency: ready op dispatched at edge N is on alu_in in cycle N+1; wakeup->issue 1 cycle (0 with ALU_RS_WAKEUP_BYPASS_EN).
// Backpressure: disp_ready drops when all DEPTH entries are occupied; alu_in holds until fu_free.
module alu_rs
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID    = 0,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  rs_disp_s             disp_op,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [XLEN-1:0]      cdb_data,
    output rs_fu_s               alu_in,
    input  logic                 fu_free,
    output logic [OCC_W-1:0]     occupancy
);

    if (DEPTH < 2 || DEPTH > 16 || ID < 0) begin : g_bad_cfg
        $error("alu_rs: DEPTH must be 2..16 and ID non-negative");
    end

    rs_entry_s        ent_q [DEPTH];
    rs_entry_s        ent_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [DEPTH-1:0] valid_vec, ready_vec, free_oh, sel_oh;
    logic             free_found, sel_found;
    logic             disp_fire, issue_fire;

    // An operand counts as available if already captured, or (bypass build) arriving on the CDB now
    function automatic logic src_ok(input rs_src_s s);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        return s.rdy || (cdb_valid && (s.tag == cdb_tag));
`else
        return s.rdy;
`endif
    endfunction

    // Per-entry occupancy and readiness vectors
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid && src_ok(ent_q[i].src_a) && src_ok(ent_q[i].src_b);
        end
    end

    lsb_pick #(.WIDTH(DEPTH)) u_free_pick (
        .req_i    (~valid_vec),
        .onehot_o (free_oh),
        .found_o  (free_found)
    );

    lsb_pick #(.WIDTH(DEPTH)) u_sel_pick (
        .req_i    (ready_vec),
        .onehot_o (sel_oh),
        .found_o  (sel_found)
    );

    // Occupancy is tracked by counter; slots freed by issue this cycle are not visible to dispatch
    assign disp_ready = (occ_q < OCC_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && free_found;
    assign issue_fire = sel_found && fu_free;
    assign occupancy  = occ_q;

    // Drive the selected entry onto alu_in; all-zero when nothing is ready
    always_comb begin
        alu_in = '0;
        if (sel_found) begin
            alu_in.valid = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_oh[i]) begin
                    alu_in.alu_ctrl = ent_q[i].alu_ctrl;
                    alu_in.dest_tag = ent_q[i].dest_tag;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
                    alu_in.operand_a = src_snoop(ent_q[i].src_a, cdb_valid, cdb_tag, cdb_data).data;
                    alu_in.operand_b = src_snoop(ent_q[i].src_b, cdb_valid, cdb_tag, cdb_data).data;
`else
                    alu_in.operand_a = ent_q[i].src_a.data;
                    alu_in.operand_b = ent_q[i].src_b.data;
`endif
                end
            end
        end
    end

    // Entry next-state: wakeup, issue retire, dispatch write (with CDB bypass), flush overrides all
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].src_a = src_snoop(ent_q[i].src_a, cdb_valid, cdb_tag, cdb_data);
                ent_d[i].src_b = src_snoop(ent_q[i].src_b, cdb_valid, cdb_tag, cdb_data);
            end
            if (issue_fire && sel_oh[i]) begin
                ent_d[i].valid = 1'b0;
            end
            if (disp_fire && free_oh[i]) begin
                ent_d[i].valid    = 1'b1;
                ent_d[i].alu_ctrl = disp_op.alu_ctrl;
                ent_d[i].dest_tag = disp_op.dest_tag;
                ent_d[i].src_a    = src_snoop(disp_op.src_a, cdb_valid, cdb_tag, cdb_data);
                ent_d[i].src_b    = src_snoop(disp_op.src_b, cdb_valid, cdb_tag, cdb_data);
            end
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    // Occupancy next-state: +dispatch -issue, zero on flush
    always_comb begin
        occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
        if (flush) begin
            occ_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: holds up to DEPTH dispatched ALU micro-ops and wakes their source operands by snooping the common data bus (CDB) broadcast. It issues one ready op per cycle to the downstream ALU execution unit through the shared `rs_fu_s` bundle and `free` handshake. It sits between rename/dispatch and the ALU.

## Interface
Parameters:
- DEPTH, 4: number of entries (2..16).
- ID, 0: CDB port index of the fed ALU; used only for debug naming.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous and active-low.
- flush  in  1  synchronous squash of all entries (branch mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  an entry is available.
- disp_op  in  rs_disp_s  fields: alu_ctrl, dest_tag, src_a/src_b each {rdy, tag[TAG_WIDTH], data[32]}.
- cdb_valid  in  1  CDB broadcast valid this cycle.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_data  in  32  broadcast result.
- alu_in  out  rs_fu_s  {valid, alu_ctrl, operand_a, operand_b, dest_tag} to the ALU.
- fu_free  in  1  ALU accepts `alu_in` at this edge.
- occupancy  out  $clog2(DEPTH+1)  valid entry count.

## Operation
- Entry state: valid, alu_ctrl, dest_tag, per operand {rdy, tag, data}. An entry is ready when valid and both rdy.
- Dispatch: fires when disp_valid && disp_ready. Writes the lowest-index invalid entry. disp_ready = (occupancy < DEPTH). A slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch bypass: if a dispatched operand has rdy=0 and cdb_valid && cdb_tag == its tag in the same cycle, it is stored with rdy=1 and data=cdb_data.
- Wakeup: for every valid entry, each non-ready operand whose tag matches a valid CDB broadcast sets rdy=1 and captures cdb_data at the edge. Both operands may wake on the same broadcast.
- Select: lowest-index ready entry drives alu_in combinationally. alu_in.valid = any ready entry. When alu_in.valid = 0, all alu_in fields are 0.
- Issue: when alu_in.valid && fu_free, the selected entry is invalidated at the edge. When fu_free = 0, alu_in must stay stable unless a lower-index entry becomes ready; the ALU only samples on fu_free.
- Flush: clears every valid bit at the edge. It overrides same-cycle dispatch, wakeup and issue. occupancy becomes 0.
- occupancy updates with the formula +dispatch −issue.

## Timing
- Reset: all entries invalid, occupancy 0, disp_ready 1, alu_in all zero.
- Dispatch → issue latency: a fully ready op dispatched at edge N is on alu_in during cycle N+1 and leaves at edge N+1 if fu_free.
- Wakeup → issue: a broadcast in cycle N makes the entry issuable in cycle N+1 (base build).
- Throughput: 1 issue/cycle, 1 dispatch/cycle.
- Full: with occupancy = DEPTH, disp_ready = 0 for the whole cycle, even if an issue happens that cycle.
- rst_n asserted mid-operation: all state clears immediately. Ops in flight are discarded.

## Configuration
- ALU_RS_WAKEUP_BYPASS_EN defined: an entry whose only missing operand(s) match the current CDB broadcast counts as ready in that same cycle. Its operand is muxed from cdb_data onto alu_in. Select priority is unchanged, so wakeup → issue latency is 0 cycles.
- Undefined: wakeup only takes effect at the edge, giving a 1-cycle wakeup → issue latency.

## Structure
- riscv_pkg gains `rs_src_s` {rdy, tag, data} and `rs_disp_s`. The entry typedef `rs_entry_s` is also placed there for reuse by other reservation stations.
- Existing `rs_fu_s`, `alu_ctrl_e` and TAG_WIDTH come from riscv_pkg.
- Sub-module `lsb_pick` (parameterised WIDTH; outputs one-hot + found) is instantiated twice: free-slot pick and ready-entry select.

## Test plan
- Reset, then dispatch ADD a=5 b=7 both ready, fu_free=1 → next cycle alu_in.valid=1, operand_a=5, operand_b=7, then occupancy returns to 0.
- Dispatch SUB with src_a waiting on tag 3, then CDB tag 3 data 0x10 → entry issues one cycle after the broadcast (bypass off) or in the same cycle (bypass on), with operand_a=0x10.
- Dispatch with src_b tag 2 while the CDB broadcasts tag 2 data 9 in the same cycle → stored ready, issues the next cycle with operand_b=9.
- Fill DEPTH=4 entries with fu_free=0 → disp_ready=0 and occupancy=4. Raise fu_free → entries 0..3 issue in index order, one per cycle, and disp_ready returns high.
- Two entries both waiting on tag 6 → a single broadcast wakes both, and they issue on consecutive cycles.
- Entries present and flush asserted along with disp_valid → next cycle occupancy=0, alu_in.valid=0, and the dispatched op is dropped.
